tap_bank_ctrl: RTL and testbench
================================

# tap_bank_ctrl

Double-buffered load controller for FIR/bias tap coefficient RAM, placed downstream of the serial-link tap-write demux. One tap-write packet at a time is written into the shadow bank and the packet is validated for address range, word count and duration. Only a clean packet is committed, by swapping active/shadow banks at a datapath-safe boundary, so the filter never runs on a partially loaded coefficient set.

## Interface
- `TAP_DEPTH`, 1024: words per bank; `AW = $clog2(TAP_DEPTH)`.
- `EXP_WORDS`, 1024: required `vld` beats per packet.
- `TIMEOUT_CYC`, 65535: maximum cycles with `tap_wr_cmd` high; 0 disables the check.
- `clk_100m`  in  1  system clock.
- `rst_100m`  in  1  reset, asynchronous, active-high.
- `cfg_clr`  in  1  synchronous clear of all state.
- `tap_wr_cmd`  in  1  packet frame; high for the whole packet.
- `tap_wr_addr`  in  32  word address of the current beat.
- `tap_wr_vld`  in  1  data beat strobe.
- `tap_wr_data`  in  32  coefficient word.
- `swap_safe`  in  1  pulse at datapath frame boundary.
- `ram_wr_en`  out  1  coefficient RAM write strobe.
- `ram_wr_bank`  out  1  target bank; always the shadow bank.
- `ram_wr_addr`  out  AW  RAM word address.
- `ram_wr_data`  out  32  RAM write data.
- `active_bank`  out  1  bank the datapath reads.
- `load_busy`  out  1  high while not IDLE.
- `load_done`  out  1  one-cycle pulse on commit.
- `load_err`  out  1  one-cycle pulse on packet rejection.
- `err_code`  out  3  last error: 1 = range, 2 = count, 3 = busy, 4 = timeout; held until the next error.
- `commit_cnt`  out  16  number of commits.
- `err_cnt`  out  16  number of rejections.

## Operation
- FSM states: IDLE, LOAD, CHECK, WAIT_SWAP, DRAIN.
- IDLE:
  - `tap_wr_cmd` rising edge → LOAD.
  - Clear the beat counter and the error flag.
- LOAD:
  - Each `vld` with `cmd=1` increments the 16-bit saturating beat counter.
  - If `addr < TAP_DEPTH` and no error is flagged, write `ram_wr_addr = addr[AW-1:0]`.
  - `addr >= TAP_DEPTH` sets flag code 1; all further writes in the packet are suppressed.
  - Timeout expiry sets code 4, suppresses writes → DRAIN.
  - `cmd` falling edge → CHECK.
- DRAIN: wait for `cmd` low → CHECK.
- CHECK (one cycle):
  - Error flagged: pulse `load_err`, update `err_code`, → IDLE.
  - Beat count ≠ EXP_WORDS: code 2, pulse `load_err`, → IDLE.
  - Otherwise → WAIT_SWAP.
- WAIT_SWAP:
  - `swap_safe` → toggle `active_bank`, pulse `load_done`, increment `commit_cnt`, → IDLE.
  - `cmd` rising edge here: the packet is dropped with no RAM writes, `load_err` pulses with code 3, and the pending commit is kept.
- On rejection the shadow contents are undefined and `active_bank` is unchanged.
- `cfg_clr`: same effect as reset.
- `commit_cnt`/`err_cnt` wrap at 16 bits.

## Timing
- Reset values: all outputs 0; `active_bank = 0`; FSM in IDLE.
- RAM write is registered: `ram_wr_*` is valid 1 cycle after the `vld` beat.
- A `vld` in the same cycle as `cmd` falling is not counted, because `cmd=0`.
- CHECK follows one cycle after `cmd` is sampled low.
- `swap_safe` is honored only in WAIT_SWAP. A pulse in the CHECK cycle is ignored, so the commit waits for the next pulse.
- `active_bank` toggle and the `load_done` pulse occur 1 cycle after `swap_safe` is sampled.
- The last RAM write of a packet always precedes `active_bank` toggling by ≥2 cycles.
- The timeout counter starts at the `cmd` rise; the error is raised on the cycle the count reaches TIMEOUT_CYC.
- Reset mid-LOAD: FSM → IDLE; in-flight `ram_wr_en` is forced low; `active_bank` → 0.

## Structure
- Package `tap_ctrl_pkg`:
  - FSM state enum.
  - Error code constants `ERR_RANGE`/`ERR_COUNT`/`ERR_BUSY`/`ERR_TIMEOUT`.
  - Default depth constant.
- Single module, no sub-modules.
- Edge detection of `cmd` is local (registered `cmd_d1`).

## Test plan
- Clean load:
  - Stimulus: 1024 beats, addr 0..1023, data = addr; then `swap_safe` 20 cycles after `cmd` falls.
  - Response: 1024 writes to bank 1; `active_bank` 0→1; `load_done` ×1; `commit_cnt = 1`.
- Range error:
  - Stimulus: beat 5 with addr 0x400.
  - Response: writes stop after beat 4; `load_err` with `err_code = 1`; `active_bank` unchanged.
- Count mismatch:
  - Stimulus: 1023 beats.
  - Response: `err_code = 2`; `err_cnt = 1`; no swap.
- Busy:
  - Stimulus: second packet starts while in WAIT_SWAP.
  - Response: no RAM writes from it; `err_code = 3`; the later `swap_safe` still commits the first packet.
- Timeout (TIMEOUT_CYC = 100):
  - Stimulus: `cmd` held high 200 cycles.
  - Response: error at cycle 100 after `cmd` rises, `err_code = 4`; FSM idles only after `cmd` falls.
- Reset/clear:
  - Stimulus: `rst_100m` mid-LOAD, then `cfg_clr` after a commit.
  - Response: all outputs 0; `active_bank = 0`; next clean load targets bank 1.

Source files
------------

// File: rtl/tap_bank_ctrl_pkg.sv
// Shared types and constants for the double-buffered tap coefficient loader.
// Holds the FSM encoding, the error codes and a saturating counter helper.
package tap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_CHECK     = 3'd2,
    ST_WAIT_SWAP = 3'd3,
    ST_DRAIN     = 3'd4
  } tap_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_RANGE   = 3'd1;
  localparam logic [2:0] ERR_COUNT   = 3'd2;
  localparam logic [2:0] ERR_BUSY    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam int unsigned TAP_DEPTH_DEF = 1024;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tap_bank_ctrl_if.sv
// Tap-write ingress and coefficient RAM write port of the tap bank controller.
// The master side is the upstream demux / RAM owner, the slave side is the controller.
interface tap_bank_ctrl_if #(
  parameter int unsigned AW = 10
);
  logic          tap_wr_cmd;
  logic [31:0]   tap_wr_addr;
  logic          tap_wr_vld;
  logic [31:0]   tap_wr_data;
  logic          swap_safe;
  logic          ram_wr_en;
  logic          ram_wr_bank;
  logic [AW-1:0] ram_wr_addr;
  logic [31:0]   ram_wr_data;

  modport master (
    output tap_wr_cmd, tap_wr_addr, tap_wr_vld, tap_wr_data, swap_safe,
    input  ram_wr_en, ram_wr_bank, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  tap_wr_cmd, tap_wr_addr, tap_wr_vld, tap_wr_data, swap_safe,
    output ram_wr_en, ram_wr_bank, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/tap_bank_ctrl.sv
// Loads one tap-write packet into the shadow coefficient bank, validates it and
// commits it by swapping banks on a datapath-safe boundary.
module tap_bank_ctrl
  import tap_ctrl_pkg::*;
#(
  parameter int unsigned TAP_DEPTH   = TAP_DEPTH_DEF,
  parameter int unsigned EXP_WORDS   = 1024,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              clk_100m,
  input  logic              rst_100m,
  input  logic              cfg_clr,
  tap_bank_ctrl_if.slave    bus,
  output logic              active_bank,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        err_code,
  output logic [15:0]       commit_cnt,
  output logic [15:0]       err_cnt
);

  localparam int unsigned AW = $clog2(TAP_DEPTH);

  tap_state_e    state_q;
  logic          cmd_d1_q;
  logic [15:0]   beat_cnt_q;
  logic [15:0]   to_cnt_q;
  logic [2:0]    flag_q;
  logic          ram_wr_en_q;
  logic          ram_wr_bank_q;
  logic [AW-1:0] ram_wr_addr_q;
  logic [31:0]   ram_wr_data_q;
  logic          active_bank_q;
  logic          load_busy_q;
  logic          load_done_q;
  logic          load_err_q;
  logic [2:0]    err_code_q;
  logic [15:0]   commit_cnt_q;
  logic [15:0]   err_cnt_q;

  logic          cmd_rise_s;
  logic          beat_s;
  logic          in_range_s;
  logic          capture_s;
  logic          timeout_s;
  logic          flag_clear_s;
  logic          wr_ok_s;
  logic          range_hit_s;

  // Beat qualification; the rising-edge cycle is treated as the first LOAD cycle
  // so a beat presented together with the frame start is not lost.
  always_comb begin
    cmd_rise_s   = bus.tap_wr_cmd & ~cmd_d1_q;
    beat_s       = bus.tap_wr_cmd & bus.tap_wr_vld;
    in_range_s   = (bus.tap_wr_addr < 32'(TAP_DEPTH));
    capture_s    = (state_q == ST_LOAD) | ((state_q == ST_IDLE) & cmd_rise_s);
    timeout_s    = 1'b0;
    if ((TIMEOUT_CYC != 0) && (state_q == ST_LOAD) && bus.tap_wr_cmd) begin
      timeout_s = ((17'(to_cnt_q) + 17'd1) >= 17'(TIMEOUT_CYC));
    end else begin
      timeout_s = 1'b0;
    end
    flag_clear_s = (state_q == ST_IDLE) | (flag_q == ERR_NONE);
    wr_ok_s      = capture_s & beat_s & in_range_s & flag_clear_s & ~timeout_s;
    range_hit_s  = capture_s & beat_s & ~in_range_s & flag_clear_s & ~timeout_s;
  end

  // Packet FSM, RAM write register, bank select and status counters.
  always_ff @(posedge clk_100m or posedge rst_100m) begin
    if (rst_100m) begin
      state_q       <= ST_IDLE;
      cmd_d1_q      <= 1'b0;
      beat_cnt_q    <= 16'd0;
      to_cnt_q      <= 16'd0;
      flag_q        <= ERR_NONE;
      ram_wr_en_q   <= 1'b0;
      ram_wr_bank_q <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= 32'd0;
      active_bank_q <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
      commit_cnt_q  <= 16'd0;
      err_cnt_q     <= 16'd0;
    end else if (cfg_clr) begin
      state_q       <= ST_IDLE;
      cmd_d1_q      <= 1'b0;
      beat_cnt_q    <= 16'd0;
      to_cnt_q      <= 16'd0;
      flag_q        <= ERR_NONE;
      ram_wr_en_q   <= 1'b0;
      ram_wr_bank_q <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= 32'd0;
      active_bank_q <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
      commit_cnt_q  <= 16'd0;
      err_cnt_q     <= 16'd0;
    end else begin
      cmd_d1_q    <= bus.tap_wr_cmd;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      ram_wr_en_q <= wr_ok_s;
      if (wr_ok_s) begin
        ram_wr_bank_q <= ~active_bank_q;
        ram_wr_addr_q <= bus.tap_wr_addr[AW-1:0];
        ram_wr_data_q <= bus.tap_wr_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (cmd_rise_s) begin
            state_q     <= ST_LOAD;
            load_busy_q <= 1'b1;
            to_cnt_q    <= 16'd0;
            beat_cnt_q  <= beat_s ? 16'd1 : 16'd0;
            flag_q      <= range_hit_s ? ERR_RANGE : ERR_NONE;
          end
        end
        ST_LOAD: begin
          if (!bus.tap_wr_cmd) begin
            state_q <= ST_CHECK;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
            if (beat_s) begin
              beat_cnt_q <= sat_inc16(beat_cnt_q);
            end
            if (timeout_s) begin
              flag_q  <= ERR_TIMEOUT;
              state_q <= ST_DRAIN;
            end else if (range_hit_s) begin
              flag_q <= ERR_RANGE;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.tap_wr_cmd) begin
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (flag_q != ERR_NONE) begin
            load_err_q  <= 1'b1;
            err_code_q  <= flag_q;
            err_cnt_q   <= err_cnt_q + 16'd1;
            state_q     <= ST_IDLE;
            load_busy_q <= 1'b0;
          end else if (beat_cnt_q != 16'(EXP_WORDS)) begin
            load_err_q  <= 1'b1;
            err_code_q  <= ERR_COUNT;
            err_cnt_q   <= err_cnt_q + 16'd1;
            state_q     <= ST_IDLE;
            load_busy_q <= 1'b0;
          end else begin
            state_q <= ST_WAIT_SWAP;
          end
        end
        ST_WAIT_SWAP: begin
          // A packet starting here is dropped; its frame stays high past the
          // commit, so IDLE never sees a fresh rising edge for it.
          if (cmd_rise_s) begin
            load_err_q <= 1'b1;
            err_code_q <= ERR_BUSY;
            err_cnt_q  <= err_cnt_q + 16'd1;
          end
          if (bus.swap_safe) begin
            active_bank_q <= ~active_bank_q;
            load_done_q   <= 1'b1;
            commit_cnt_q  <= commit_cnt_q + 16'd1;
            state_q       <= ST_IDLE;
            load_busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          load_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_wr_bank = ram_wr_bank_q;
  assign bus.ram_wr_addr = ram_wr_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;
  assign active_bank     = active_bank_q;
  assign load_busy       = load_busy_q;
  assign load_done       = load_done_q;
  assign load_err        = load_err_q;
  assign err_code        = err_code_q;
  assign commit_cnt      = commit_cnt_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_tap_bank_ctrl.sv
// Directed bench for tap_bank_ctrl: default instance for load/commit/error paths,
// a second instance with a 100-cycle timeout for the timeout path.
module tb_tap_bank_ctrl;

  logic clk_100m;
  logic rst_100m;
  logic cfg_clr_a;
  logic cfg_clr_b;

  tap_bank_ctrl_if #(.AW(10)) bus_a ();
  tap_bank_ctrl_if #(.AW(10)) bus_b ();

  logic        active_a, busy_a, done_a, err_a;
  logic [2:0]  code_a;
  logic [15:0] ccnt_a, ecnt_a;
  logic        active_b, busy_b, done_b, err_b;
  logic [2:0]  code_b;
  logic [15:0] ccnt_b, ecnt_b;

  int n_vec = 0;
  int n_bad = 0;

  int wr_a = 0, wr_b1_a = 0, bad_data_a = 0, done_cnt_a = 0;
  int wr_b = 0;

  tap_bank_ctrl dut_a (
    .clk_100m    (clk_100m),
    .rst_100m    (rst_100m),
    .cfg_clr     (cfg_clr_a),
    .bus         (bus_a),
    .active_bank (active_a),
    .load_busy   (busy_a),
    .load_done   (done_a),
    .load_err    (err_a),
    .err_code    (code_a),
    .commit_cnt  (ccnt_a),
    .err_cnt     (ecnt_a)
  );

  tap_bank_ctrl #(.TIMEOUT_CYC(100)) dut_b (
    .clk_100m    (clk_100m),
    .rst_100m    (rst_100m),
    .cfg_clr     (cfg_clr_b),
    .bus         (bus_b),
    .active_bank (active_b),
    .load_busy   (busy_b),
    .load_done   (done_b),
    .load_err    (err_b),
    .err_code    (code_b),
    .commit_cnt  (ccnt_b),
    .err_cnt     (ecnt_b)
  );

  always #5 clk_100m = ~clk_100m;

  // Observe RAM writes and commit pulses away from the active edge.
  always @(negedge clk_100m) begin
    if (bus_a.ram_wr_en) begin
      wr_a <= wr_a + 1;
      if (bus_a.ram_wr_bank) wr_b1_a <= wr_b1_a + 1;
      if (bus_a.ram_wr_data != {22'd0, bus_a.ram_wr_addr}) bad_data_a <= bad_data_a + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (bus_b.ram_wr_en) wr_b <= wr_b + 1;
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  // Drives nbeats back-to-back beats, addr = data = index, except bad_idx which gets 0x400.
  // Returns with the FSM in CHECK.
  task automatic send_a(input int nbeats, input int bad_idx);
    for (int i = 0; i < nbeats; i++) begin
      bus_a.tap_wr_cmd  = 1'b1;
      bus_a.tap_wr_vld  = 1'b1;
      bus_a.tap_wr_addr = (i == bad_idx) ? 32'h0000_0400 : 32'(i);
      bus_a.tap_wr_data = bus_a.tap_wr_addr;
      tick();
    end
    bus_a.tap_wr_cmd  = 1'b0;
    bus_a.tap_wr_vld  = 1'b0;
    bus_a.tap_wr_addr = 32'd0;
    bus_a.tap_wr_data = 32'd0;
    tick();
  endtask

  task automatic pulse_swap_a();
    bus_a.swap_safe = 1'b1;
    tick();
    bus_a.swap_safe = 1'b0;
  endtask

  task automatic test_reset();
    rst_100m = 1'b1;
    repeat (3) tick();
    rst_100m = 1'b0;
    tick();
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %0d want 0", active_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d want 0", busy_a); end
    n_vec++; if ({done_a, err_a, code_a} !== 5'd0) begin n_bad++; $display("FAIL reset_pulses: got %0h want 0", {done_a, err_a, code_a}); end
    n_vec++; if ({ccnt_a, ecnt_a} !== 32'd0) begin n_bad++; $display("FAIL reset_counts: got %0h want 0", {ccnt_a, ecnt_a}); end
    n_vec++; if (bus_a.ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %0d want 0", bus_a.ram_wr_en); end
  endtask

  task automatic test_clean_load();
    int w0, b0, bd0, d0;
    w0 = wr_a; b0 = wr_b1_a; bd0 = bad_data_a; d0 = done_cnt_a;
    send_a(1024, -1);
    tick();
    n_vec++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL clean_wait_busy: got %0d want 1", busy_a); end
    n_vec++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL clean_no_err: got %0d want 0", err_a); end
    repeat (18) tick();
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL clean_pre_swap: got %0d want 0", active_a); end
    pulse_swap_a();
    n_vec++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL clean_active: got %0d want 1", active_a); end
    n_vec++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL clean_done: got %0d want 1", done_a); end
    tick();
    n_vec++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL clean_done_pulse: got %0d want 0", done_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL clean_idle: got %0d want 0", busy_a); end
    n_vec++; if (ccnt_a !== 16'd1) begin n_bad++; $display("FAIL clean_commit_cnt: got %0d want 1", ccnt_a); end
    n_vec++; if (wr_a - w0 != 1024) begin n_bad++; $display("FAIL clean_writes: got %0d want 1024", wr_a - w0); end
    n_vec++; if (wr_b1_a - b0 != 1024) begin n_bad++; $display("FAIL clean_bank1: got %0d want 1024", wr_b1_a - b0); end
    n_vec++; if (bad_data_a - bd0 != 0) begin n_bad++; $display("FAIL clean_data: got %0d want 0", bad_data_a - bd0); end
    n_vec++; if (done_cnt_a - d0 != 1) begin n_bad++; $display("FAIL clean_done_cnt: got %0d want 1", done_cnt_a - d0); end
  endtask

  task automatic test_count_mismatch();
    int w0;
    w0 = wr_a;
    send_a(1023, -1);
    tick();
    n_vec++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL count_err: got %0d want 1", err_a); end
    n_vec++; if (code_a !== 3'd2) begin n_bad++; $display("FAIL count_code: got %0d want 2", code_a); end
    n_vec++; if (ecnt_a !== 16'd1) begin n_bad++; $display("FAIL count_err_cnt: got %0d want 1", ecnt_a); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL count_idle: got %0d want 0", busy_a); end
    n_vec++; if (wr_a - w0 != 1023) begin n_bad++; $display("FAIL count_writes: got %0d want 1023", wr_a - w0); end
    repeat (5) tick();
    pulse_swap_a();
    tick();
    n_vec++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL count_no_swap: got %0d want 1", active_a); end
    n_vec++; if (ccnt_a !== 16'd1) begin n_bad++; $display("FAIL count_commit_cnt: got %0d want 1", ccnt_a); end
  endtask

  task automatic test_range_error();
    int w0;
    w0 = wr_a;
    // fifth beat (index 4) is out of range; only the four before it land in RAM
    send_a(10, 4);
    tick();
    n_vec++; if (wr_a - w0 != 4) begin n_bad++; $display("FAIL range_writes: got %0d want 4", wr_a - w0); end
    n_vec++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL range_err: got %0d want 1", err_a); end
    n_vec++; if (code_a !== 3'd1) begin n_bad++; $display("FAIL range_code: got %0d want 1", code_a); end
    n_vec++; if (ecnt_a !== 16'd2) begin n_bad++; $display("FAIL range_err_cnt: got %0d want 2", ecnt_a); end
    n_vec++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL range_active: got %0d want 1", active_a); end
  endtask

  task automatic test_busy();
    int w0;
    send_a(1024, -1);
    tick();
    repeat (3) tick();
    w0 = wr_a;
    for (int i = 0; i < 6; i++) begin
      bus_a.tap_wr_cmd  = 1'b1;
      bus_a.tap_wr_vld  = 1'b1;
      bus_a.tap_wr_addr = 32'(i + 7);
      bus_a.tap_wr_data = 32'(i + 7);
      tick();
      if (i == 0) begin
        n_vec++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL busy_err: got %0d want 1", err_a); end
        n_vec++; if (code_a !== 3'd3) begin n_bad++; $display("FAIL busy_code: got %0d want 3", code_a); end
        n_vec++; if (ecnt_a !== 16'd3) begin n_bad++; $display("FAIL busy_err_cnt: got %0d want 3", ecnt_a); end
      end
    end
    bus_a.tap_wr_cmd = 1'b0;
    bus_a.tap_wr_vld = 1'b0;
    repeat (3) tick();
    n_vec++; if (wr_a - w0 != 0) begin n_bad++; $display("FAIL busy_no_writes: got %0d want 0", wr_a - w0); end
    n_vec++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL busy_still_pending: got %0d want 1", busy_a); end
    pulse_swap_a();
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL busy_commit_active: got %0d want 0", active_a); end
    tick();
    n_vec++; if (ccnt_a !== 16'd2) begin n_bad++; $display("FAIL busy_commit_cnt: got %0d want 2", ccnt_a); end
  endtask

  task automatic test_swap_in_check();
    send_a(1024, -1);
    bus_a.swap_safe = 1'b1;
    tick();
    bus_a.swap_safe = 1'b0;
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL check_swap_ignored: got %0d want 0", active_a); end
    n_vec++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL check_swap_busy: got %0d want 1", busy_a); end
    repeat (5) tick();
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL check_swap_hold: got %0d want 0", active_a); end
    pulse_swap_a();
    n_vec++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL check_swap_commit: got %0d want 1", active_a); end
    tick();
    n_vec++; if (ccnt_a !== 16'd3) begin n_bad++; $display("FAIL check_swap_cnt: got %0d want 3", ccnt_a); end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = wr_b;
    for (int i = 0; i < 200; i++) begin
      bus_b.tap_wr_cmd  = 1'b1;
      bus_b.tap_wr_vld  = 1'b1;
      bus_b.tap_wr_addr = 32'(i);
      bus_b.tap_wr_data = 32'(i);
      tick();
      if (i == 150) begin
        n_vec++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL timeout_drain_busy: got %0d want 1", busy_b); end
        n_vec++; if (err_b !== 1'b0) begin n_bad++; $display("FAIL timeout_early_err: got %0d want 0", err_b); end
      end
    end
    bus_b.tap_wr_cmd = 1'b0;
    bus_b.tap_wr_vld = 1'b0;
    tick();
    n_vec++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL timeout_check_busy: got %0d want 1", busy_b); end
    tick();
    n_vec++; if (err_b !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_b); end
    n_vec++; if (code_b !== 3'd4) begin n_bad++; $display("FAIL timeout_code: got %0d want 4", code_b); end
    n_vec++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL timeout_idle: got %0d want 0", busy_b); end
    n_vec++; if (wr_b - w0 != 100) begin n_bad++; $display("FAIL timeout_writes: got %0d want 100", wr_b - w0); end
    n_vec++; if (active_b !== 1'b0) begin n_bad++; $display("FAIL timeout_active: got %0d want 0", active_b); end
  endtask

  task automatic test_reset_clear();
    int b0;
    for (int i = 0; i < 10; i++) begin
      bus_a.tap_wr_cmd  = 1'b1;
      bus_a.tap_wr_vld  = 1'b1;
      bus_a.tap_wr_addr = 32'(i);
      bus_a.tap_wr_data = 32'(i);
      tick();
    end
    #2;
    rst_100m = 1'b1;
    #1;
    n_vec++; if (bus_a.ram_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %0d want 0", bus_a.ram_wr_en); end
    n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d want 0", busy_a); end
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL rst_active: got %0d want 0", active_a); end
    n_vec++; if ({ccnt_a, ecnt_a, code_a} !== 35'd0) begin n_bad++; $display("FAIL rst_status: got %0h want 0", {ccnt_a, ecnt_a, code_a}); end
    bus_a.tap_wr_cmd = 1'b0;
    bus_a.tap_wr_vld = 1'b0;
    tick();
    rst_100m = 1'b0;
    repeat (2) tick();
    send_a(1024, -1);
    tick();
    repeat (4) tick();
    pulse_swap_a();
    tick();
    n_vec++; if ({active_a, ccnt_a} !== 17'h1_0001) begin n_bad++; $display("FAIL rst_reload: got %0h want 10001", {active_a, ccnt_a}); end
    cfg_clr_a = 1'b1;
    tick();
    cfg_clr_a = 1'b0;
    n_vec++; if (active_a !== 1'b0) begin n_bad++; $display("FAIL clr_active: got %0d want 0", active_a); end
    n_vec++; if ({busy_a, done_a, err_a, code_a, ccnt_a, ecnt_a} !== 38'd0) begin n_bad++; $display("FAIL clr_status: got %0h want 0", {busy_a, done_a, err_a, code_a, ccnt_a, ecnt_a}); end
    b0 = wr_b1_a;
    send_a(1024, -1);
    tick();
    n_vec++; if (wr_b1_a - b0 != 1024) begin n_bad++; $display("FAIL clr_bank1: got %0d want 1024", wr_b1_a - b0); end
    pulse_swap_a();
    n_vec++; if (active_a !== 1'b1) begin n_bad++; $display("FAIL clr_commit: got %0d want 1", active_a); end
  endtask

  initial begin
    clk_100m  = 1'b0;
    rst_100m  = 1'b1;
    cfg_clr_a = 1'b0;
    cfg_clr_b = 1'b0;
    bus_a.tap_wr_cmd = 1'b0; bus_a.tap_wr_vld = 1'b0; bus_a.tap_wr_addr = 32'd0; bus_a.tap_wr_data = 32'd0; bus_a.swap_safe = 1'b0;
    bus_b.tap_wr_cmd = 1'b0; bus_b.tap_wr_vld = 1'b0; bus_b.tap_wr_addr = 32'd0; bus_b.tap_wr_data = 32'd0; bus_b.swap_safe = 1'b0;
    test_reset();
    test_clean_load();
    test_count_mismatch();
    test_range_error();
    test_busy();
    test_swap_in_check();
    test_timeout();
    test_reset_clear();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
